coin_sensor_classifier: RTL

//  Front end of the coin path. Takes the five raw optical coin-sensor lines, synchronises and debounces them.

---
 rtl/coin_pkg.sv | 58 +++++
 rtl/sensor_debounce.sv | 45 ++++
 rtl/coin_sensor_classifier.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared state encoding, coin codes, thermometer patterns and BCD table
// for the coin sensor front end.
package coin_pkg;

    localparam int unsigned SENSOR_W = 5;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned BCD_W    = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_GAP      = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_JAM      = 3'd4
    } state_t;

    localparam logic [CODE_W-1:0] COIN_NONE = 3'd0;
    localparam logic [CODE_W-1:0] COIN_5    = 3'd1;
    localparam logic [CODE_W-1:0] COIN_10   = 3'd2;
    localparam logic [CODE_W-1:0] COIN_20   = 3'd3;
    localparam logic [CODE_W-1:0] COIN_50   = 3'd4;
    localparam logic [CODE_W-1:0] COIN_100  = 3'd5;

    localparam logic [SENSOR_W-1:0] THERM_5   = 5'b00001;
    localparam logic [SENSOR_W-1:0] THERM_10  = 5'b00011;
    localparam logic [SENSOR_W-1:0] THERM_20  = 5'b00111;
    localparam logic [SENSOR_W-1:0] THERM_50  = 5'b01111;
    localparam logic [SENSOR_W-1:0] THERM_100 = 5'b11111;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [BCD_W-1:0]  bcd;
    } coin_event_t;

    // Anything that is not a clean thermometer code maps to COIN_NONE.
    function automatic logic [CODE_W-1:0] pattern_to_code(input logic [SENSOR_W-1:0] pattern);
        case (pattern)
            THERM_5:   return COIN_5;
            THERM_10:  return COIN_10;
            THERM_20:  return COIN_20;
            THERM_50:  return COIN_50;
            THERM_100: return COIN_100;
            default:   return COIN_NONE;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] code_to_bcd(input logic [CODE_W-1:0] code);
        case (code)
            COIN_5:   return 12'h005;
            COIN_10:  return 12'h010;
            COIN_20:  return 12'h020;
            COIN_50:  return 12'h050;
            COIN_100: return 12'h100;
            default:  return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor line: 2-FF synchroniser followed by a debounce counter that
// only lets the output follow after DEBOUNCE_CYCLES consecutive equal samples.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic CLK_50,
    input  logic rst,
    input  logic sensor_i,
    output logic deb_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    // Count samples that disagree with the current output; any agreeing sample restarts.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sensor_i};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/coin_sensor_classifier.sv
// Coin path front end: debounces the five sensor lines, tracks a coin passage,
// classifies it and holds one event for the accumulator. Optional COIN_STATS_EN
// adds a saturating count of delivered events.
module coin_sensor_classifier
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned GAP_CYCLES      = 500_000,
    parameter int unsigned JAM_CYCLES      = 50_000_000
) (
    input  logic        CLK_50,
    input  logic        rst,
    input  logic [4:0]  sensor,
    output logic        coin_valid,
    output logic [2:0]  coin_code,
    output logic [11:0] coin_bcd,
    input  logic        coin_ack,
    output logic        coin_err,
    output logic        jam,
    output logic        overflow,
`ifdef COIN_STATS_EN
    output logic [15:0] coin_count,
`endif
    output logic        busy
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned JAM_W = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;

    logic [SENSOR_W-1:0] deb;

    state_t              state_q, state_d;
    logic [SENSOR_W-1:0] pattern_q, pattern_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [JAM_W-1:0]    jam_cnt_q, jam_cnt_d;
    logic                busy_q, jam_q, coin_err_q, coin_err_d;

    coin_event_t         evt_q, evt_d;
    logic                valid_q, valid_d;
    logic                overflow_q, overflow_d;
    logic [CODE_W-1:0]   offer_code;
    logic                offer, load;

    for (genvar i = 0; i < SENSOR_W; i++) begin : g_deb
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK_50  (CLK_50),
            .rst     (rst),
            .sensor_i(sensor[i]),
            .deb_o   (deb[i])
        );
    end

    // Passage tracking FSM: next state, pattern and counters.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        gap_cnt_d = gap_cnt_q;
        jam_cnt_d = jam_cnt_q;
        case (state_q)
            ST_IDLE: begin
                pattern_d = '0;
                if (|deb) begin
                    state_d   = ST_ACCUM;
                    pattern_d = deb;
                    jam_cnt_d = '0;
                end
            end
            ST_ACCUM: begin
                pattern_d = pattern_q | deb;
                jam_cnt_d = (jam_cnt_q == '1) ? jam_cnt_q : jam_cnt_q + JAM_W'(1);
                if (jam_cnt_q == JAM_W'(JAM_CYCLES - 1)) begin
                    state_d   = ST_JAM;
                    gap_cnt_d = '0;
                end else if (deb == '0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                pattern_d = pattern_q | deb;
                gap_cnt_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);
                if (deb != '0) begin
                    state_d = ST_ACCUM;
                end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                state_d = ST_IDLE;
            end
            ST_JAM: begin
                pattern_d = '0;
                if (deb != '0) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pattern_d = '0;
            end
        endcase
    end

    // Error flag is looked ahead so it is high exactly during the CLASSIFY cycle.
    assign coin_err_d = (state_d == ST_CLASSIFY) && (pattern_to_code(pattern_d) == COIN_NONE);

    assign offer_code = pattern_to_code(pattern_q);
    assign offer      = (state_q == ST_CLASSIFY) && (offer_code != COIN_NONE);
    assign load       = offer && (!valid_q || coin_ack);

    // One-deep event holding register with ack handshake.
    always_comb begin
        evt_d      = evt_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (offer) begin
            if (load) begin
                evt_d.code = offer_code;
                evt_d.bcd  = code_to_bcd(offer_code);
                valid_d    = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && coin_ack) begin
            evt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pattern_q  <= '0;
            gap_cnt_q  <= '0;
            jam_cnt_q  <= '0;
            busy_q     <= 1'b0;
            jam_q      <= 1'b0;
            coin_err_q <= 1'b0;
            evt_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            gap_cnt_q  <= gap_cnt_d;
            jam_cnt_q  <= jam_cnt_d;
            busy_q     <= (state_d != ST_IDLE);
            jam_q      <= (state_d == ST_JAM);
            coin_err_q <= coin_err_d;
            evt_q      <= evt_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef COIN_STATS_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign coin_count = count_q;
`endif

    assign coin_valid = valid_q;
    assign coin_code  = evt_q.code;
    assign coin_bcd   = evt_q.bcd;
    assign coin_err   = coin_err_q;
    assign jam        = jam_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule
